// File: rtl/seg14_pkg.sv
// rtl/seg14_pkg.sv - shared state type, character codes and font constants for the 14-segment scheduler
package seg14_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, SCROLL = 2'd2} state_t;

   localparam logic [5:0] CH_SPACE = 6'd0;
   localparam logic [5:0] CH_A     = 6'd1;
   localparam logic [5:0] CH_E     = 6'd5;
   localparam logic [5:0] CH_P     = 6'd16;
   localparam logic [5:0] CH_S     = 6'd19;
   localparam logic [5:0] CH_T     = 6'd20;
   localparam logic [5:0] CH_Z     = 6'd26;
   localparam logic [5:0] CH_0     = 6'd27;
   localparam logic [5:0] CH_9     = 6'd36;

   // Segment order MSB..LSB: a b c d e f g1 g2 h i j k l m
   localparam logic [13:0] FONT_SPACE = 14'b00000000000000;
   localparam logic [13:0] FONT_A     = 14'b11101111000000;
   localparam logic [13:0] FONT_E     = 14'b10011110000000;
   localparam logic [13:0] FONT_P     = 14'b11001111000000;
   localparam logic [13:0] FONT_S     = 14'b10110111000000;
   localparam logic [13:0] FONT_T     = 14'b10000000010010;

endpackage

// File: rtl/seg14_font.sv
// rtl/seg14_font.sv - 6-bit character code to 14-segment pattern ROM
module seg14_font
   import seg14_pkg::*;
(
   input  logic [5:0]  i_code,
   output logic [13:0] o_seg
);

   always_comb begin
      o_seg = FONT_SPACE;
      case (i_code)
         CH_A:  o_seg = FONT_A;
         6'd2:  o_seg = 14'b11110001010010;
         6'd3:  o_seg = 14'b10011100000000;
         6'd4:  o_seg = 14'b11110000010010;
         CH_E:  o_seg = FONT_E;
         6'd6:  o_seg = 14'b10001110000000;
         6'd7:  o_seg = 14'b10111101000000;
         6'd8:  o_seg = 14'b01101111000000;
         6'd9:  o_seg = 14'b10010000010010;
         6'd10: o_seg = 14'b01111000000000;
         6'd11: o_seg = 14'b00001110001100;
         6'd12: o_seg = 14'b00011100000000;
         6'd13: o_seg = 14'b01101100101000;
         6'd14: o_seg = 14'b01101100100100;
         6'd15: o_seg = 14'b11111100000000;
         CH_P:  o_seg = FONT_P;
         6'd17: o_seg = 14'b11111100000100;
         6'd18: o_seg = 14'b11001111000100;
         CH_S:  o_seg = FONT_S;
         CH_T:  o_seg = FONT_T;
         6'd21: o_seg = 14'b01111100000000;
         6'd22: o_seg = 14'b00001100001001;
         6'd23: o_seg = 14'b01101100000101;
         6'd24: o_seg = 14'b00000000101101;
         6'd25: o_seg = 14'b00000000101010;
         CH_Z:  o_seg = 14'b10010000001001;
         CH_0:  o_seg = 14'b11111100001001;
         6'd28: o_seg = 14'b01100000000000;
         6'd29: o_seg = 14'b11011011000000;
         6'd30: o_seg = 14'b11110011000000;
         6'd31: o_seg = 14'b01100111000000;
         6'd32: o_seg = 14'b10110111000000;
         6'd33: o_seg = 14'b10111111000000;
         6'd34: o_seg = 14'b11100000000000;
         6'd35: o_seg = 14'b11111111000000;
         CH_9:  o_seg = 14'b11110111000000;
         default: o_seg = FONT_SPACE;
      endcase
   end

endmodule

// File: rtl/seg14_msg_sched.sv
// rtl/seg14_msg_sched.sv - message buffer, refresh prescaler and static/scroll scheduler for a multiplexed 14-segment display
module seg14_msg_sched
   import seg14_pkg::*;
#(
   parameter int DIGITS        = 12,
   parameter int MSG_DEPTH     = 32,
   parameter int REFRESH_DIV   = 1000,
   parameter int SCROLL_FRAMES = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [4:0]        wr_addr,
   input  logic [5:0]        wr_char,
   input  logic [5:0]        msg_len,
   input  logic              scroll_en,
   input  logic              start,
   input  logic              stop,
   output logic              busy,
   output logic [DIGITS-1:0] sel,
   output logic [13:0]       segm
);

   localparam int PW = (REFRESH_DIV > 1)   ? $clog2(REFRESH_DIV)   : 1;
   localparam int IW = (DIGITS > 1)        ? $clog2(DIGITS)        : 1;
   localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

   state_t            r_state, w_next;
   logic [PW-1:0]     r_presc;
   logic [IW-1:0]     r_idx;
   logic [FW-1:0]     r_frame;
   logic [5:0]        r_offset, r_len;
   logic [5:0]        r_buf [0:MSG_DEPTH-1];
   logic [DIGITS-1:0] r_sel;
   logic [13:0]       r_segm;

   logic              w_idle, w_start_ok, w_presc_tc, w_idx_last, w_frame_tc, w_active;
   logic [5:0]        w_p, w_rd_addr, w_char;
   logic [13:0]       w_seg;
   logic              w_unused;

   assign w_idle     = (r_state == IDLE);
   assign w_start_ok = start && (msg_len != 6'd0) && ({1'b0, msg_len} <= 7'(MSG_DEPTH));
   assign w_presc_tc = (r_presc == PW'(REFRESH_DIV - 1));
   assign w_idx_last = (r_idx == IW'(DIGITS - 1));
   assign w_frame_tc = (r_frame == FW'(SCROLL_FRAMES - 1));
   assign w_active   = !w_idle && !stop;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_start_ok)
               w_next = (scroll_en && msg_len > 6'(DIGITS)) ? SCROLL : SHOW;
         end
         default: begin
            if (stop) w_next = IDLE;
         end
      endcase
   end

   // Writes are only possible in IDLE, so the combinational read never races them.
   always_ff @(posedge clk) begin
      if (wr_valid && w_idle) r_buf[wr_addr] <= wr_char;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc  <= '0;
         r_idx    <= '0;
         r_frame  <= '0;
         r_offset <= '0;
         r_len    <= '0;
      end else if (w_idle) begin
         if (w_start_ok) begin
            r_presc  <= '0;
            r_idx    <= '0;
            r_frame  <= '0;
            r_offset <= '0;
            r_len    <= msg_len;
         end
      end else if (!stop) begin
         if (w_presc_tc) begin
            r_presc <= '0;
            r_idx   <= w_idx_last ? '0 : r_idx + 1'b1;
            if (w_idx_last && r_state == SCROLL) begin
               if (w_frame_tc) begin
                  r_frame  <= '0;
                  r_offset <= (r_offset + 6'd1 == r_len) ? 6'd0 : r_offset + 6'd1;
               end else begin
                  r_frame <= r_frame + 1'b1;
               end
            end
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   // offset < len and idx < len, so one conditional subtract wraps the scroll position.
   assign w_p       = r_offset + 6'(r_idx);
   assign w_rd_addr = (r_state == SCROLL) ? ((w_p >= r_len) ? w_p - r_len : w_p) : 6'(r_idx);
   assign w_char    = (r_state == SCROLL || 6'(r_idx) < r_len) ? r_buf[w_rd_addr[4:0]] : CH_SPACE;
   assign w_unused  = w_rd_addr[5];

   seg14_font u_font (
      .i_code (w_char),
      .o_seg  (w_seg)
   );

   always_ff @(posedge clk) begin
      if (rst || !w_active) begin
         r_sel  <= '0;
         r_segm <= '0;
      end else begin
         r_sel  <= DIGITS'(1) << r_idx;
         r_segm <= w_seg;
      end
   end

   assign sel      = r_sel;
   assign segm     = r_segm;
   assign busy     = !w_idle;
   assign wr_ready = w_idle;

endmodule

// File: tb/tb_seg14_msg_sched.sv
// tb/tb_seg14_msg_sched.sv - self-checking bench for seg14_msg_sched with a frame-arithmetic reference model
module tb_seg14_msg_sched;

   localparam int DIGITS = 12;
   localparam int MSG_DEPTH = 32;
   localparam int RD = 2;
   localparam int SF = 2;

   localparam logic [13:0] FT [0:36] = '{
      14'b00000000000000, 14'b11101111000000, 14'b11110001010010, 14'b10011100000000,
      14'b11110000010010, 14'b10011110000000, 14'b10001110000000, 14'b10111101000000,
      14'b01101111000000, 14'b10010000010010, 14'b01111000000000, 14'b00001110001100,
      14'b00011100000000, 14'b01101100101000, 14'b01101100100100, 14'b11111100000000,
      14'b11001111000000, 14'b11111100000100, 14'b11001111000100, 14'b10110111000000,
      14'b10000000010010, 14'b01111100000000, 14'b00001100001001, 14'b01101100000101,
      14'b00000000101101, 14'b00000000101010, 14'b10010000001001, 14'b11111100001001,
      14'b01100000000000, 14'b11011011000000, 14'b11110011000000, 14'b01100111000000,
      14'b10110111000000, 14'b10111111000000, 14'b11100000000000, 14'b11111111000000,
      14'b11110111000000};

   logic clk = 1'b0;
   logic rst, wr_valid, scroll_en, start, stop;
   logic [4:0] wr_addr;
   logic [5:0] wr_char, msg_len;
   logic wr_ready, busy;
   logic [DIGITS-1:0] sel;
   logic [13:0] segm;

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seg14_msg_sched #(
      .DIGITS        (DIGITS),
      .MSG_DEPTH     (MSG_DEPTH),
      .REFRESH_DIV   (RD),
      .SCROLL_FRAMES (SF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_char   (wr_char),
      .msg_len   (msg_len),
      .scroll_en (scroll_en),
      .start     (start),
      .stop      (stop),
      .busy      (busy),
      .sel       (sel),
      .segm      (segm)
   );

   // Model: mode 0 idle, 1 static, 2 scroll; m_t = edges since the accepted start.
   logic [5:0] m_buf [0:31];
   int m_mode = 0;
   int m_len = 1;
   int m_t = 0;
   bit m_armed = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_mode  <= 0;
         m_armed <= 1'b1;
      end else if (m_mode == 0) begin
         if (wr_valid) m_buf[wr_addr] <= wr_char;
         if (start && msg_len >= 1 && msg_len <= MSG_DEPTH) begin
            m_len  <= int'(msg_len);
            m_t    <= 0;
            m_mode <= (scroll_en && msg_len > DIGITS) ? 2 : 1;
         end
      end else if (stop) begin
         m_mode <= 0;
      end else begin
         m_t <= m_t + 1;
      end
   end

   function automatic logic [13:0] fnt(input int c);
      return (c >= 0 && c <= 36) ? FT[c] : 14'd0;
   endfunction

   function automatic logic [25:0] expect_out(input int mode, input int t, input int len);
      int n, idx, off, c;
      if (mode == 0 || t == 0) return '0;
      n   = t - 1;
      idx = (n / RD) % DIGITS;
      off = ((n / (RD * DIGITS)) / SF) % len;
      if (mode == 2) c = int'(m_buf[(off + idx) % len]);
      else           c = (idx < len) ? int'(m_buf[idx]) : 0;
      return {12'(1) << idx, fnt(c)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_armed) begin
         check("model_busy", {31'd0, busy}, {31'd0, m_mode != 0});
         check("model_wr_ready", {31'd0, wr_ready}, {31'd0, m_mode == 0});
         check("model_sel_segm", {6'd0, sel, segm}, {6'd0, expect_out(m_mode, m_t, m_len)});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input int a, input int c);
      wr_valid = 1'b1; wr_addr = 5'(a); wr_char = 6'(c);
      tick(1);
      wr_valid = 1'b0;
   endtask

   task automatic go(input int len, input logic se);
      start = 1'b1; msg_len = 6'(len); scroll_en = se;
      tick(1);
      start = 1'b0;
   endtask

   task automatic halt();
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_char = '0;
      msg_len = '0; scroll_en = 1'b0; start = 1'b0; stop = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(50);
      check("idle_sel", 32'(sel), 32'h0);
      check("idle_segm", 32'(segm), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_wr_ready", 32'(wr_ready), 32'h1);

      // Static "PASS"
      wr(0, 16); wr(1, 1); wr(2, 19); wr(3, 19);
      go(4, 1'b0);
      check("show_busy_t0", 32'(busy), 32'h1);
      check("show_sel_t0", 32'(sel), 32'h0);
      tick(1);
      check("show_sel_d0", 32'(sel), 32'h001);
      check("show_segm_P", 32'(segm), 32'(14'b11001111000000));
      tick(2);
      check("show_sel_d1", 32'(sel), 32'h002);
      check("show_segm_A", 32'(segm), 32'(14'b11101111000000));
      tick(6);
      check("show_sel_d4", 32'(sel), 32'h010);
      check("show_segm_blank", 32'(segm), 32'h0);
      tick(16);
      check("show_repeat_sel", 32'(sel), 32'h001);
      check("show_repeat_P", 32'(segm), 32'(14'b11001111000000));
      tick(10);
      halt();
      check("stop_sel", 32'(sel), 32'h0);
      check("stop_busy", 32'(busy), 32'h0);

      // Scroll 14 chars A..N
      for (int i = 0; i < 14; i++) wr(i, i + 1);
      go(14, 1'b1);
      tick(49);
      check("scroll_off1_sel", 32'(sel), 32'h001);
      check("scroll_off1_B", 32'(segm), 32'(14'b11110001010010));
      tick(576);
      check("scroll_off13_N", 32'(segm), 32'(14'b01101100100100));
      tick(22);
      check("scroll_off13_d11_sel", 32'(sel), 32'h800);
      check("scroll_off13_d11_K", 32'(segm), 32'(14'b00001110001100));
      tick(26);
      check("scroll_wrap_A", 32'(segm), 32'(14'b11101111000000));
      halt();

      // Write held during SHOW, accepted after stop
      go(4, 1'b0);
      tick(5);
      wr_valid = 1'b1; wr_addr = 5'd0; wr_char = 6'd20;
      tick(5);
      check("show_wr_ready", 32'(wr_ready), 32'h0);
      halt();
      check("stop_wr_ready", 32'(wr_ready), 32'h1);
      check("stop_segm", 32'(segm), 32'h0);
      tick(1);
      wr_valid = 1'b0;
      go(4, 1'b0);
      tick(1);
      check("pending_write_T", 32'(segm), 32'(14'b10000000010010));
      halt();

      // Illegal lengths, then write+start in the same cycle
      go(0, 1'b0);
      check("len0_busy", 32'(busy), 32'h0);
      go(33, 1'b0);
      check("len33_busy", 32'(busy), 32'h0);
      check("len33_sel", 32'(sel), 32'h0);
      wr_valid = 1'b1; wr_addr = 5'd1; wr_char = 6'd5;
      go(4, 1'b0);
      wr_valid = 1'b0;
      tick(3);
      check("wr_start_sel", 32'(sel), 32'h002);
      check("wr_start_E", 32'(segm), 32'(14'b10011110000000));
      halt();

      // Reset mid-scroll at digit 5
      for (int i = 0; i < 14; i++) wr(i, i + 14);
      go(14, 1'b1);
      tick(59);
      check("pre_rst_sel_d5", 32'(sel), 32'h020);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_segm", 32'(segm), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      go(14, 1'b1);
      tick(1);
      check("restart_d0_N", 32'(segm), 32'(14'b01101100100100));
      tick(10);
      check("restart_d5_S", 32'(segm), 32'(14'b10110111000000));
      halt();
      tick(5);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
